term_ctrl: RTL and testbench

Parametrised character-stream terminal controller, the next generation of the serial terminal's control layer. It accepts bytes over a valid/ready handshake and interprets control characters. It writes printable characters into the text VRAM in teletype mode with auto-margin, and runs scroll and clear sequences directly on the VRAM port. It sits between the UART receiver and the text/VRAM renderer, and exports the cursor position for the cursor overlay.

---
 rtl/term_ctrl.sv | 154 +++++++++++++++
 tb/tb_term_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/term_ctrl.sv
// term_ctrl: byte-stream terminal controller driving a text VRAM with teletype writes, scroll and clear
module term_ctrl #(
  parameter int COLS = 60,
  parameter int ROWS = 17,
  parameter int COL_W = 6,
  parameter int ROW_W = 5,
  parameter int TAB_W = 8,
  parameter logic [7:0] BLANK = 8'h20,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_char,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [ROW_W+COL_W-1:0] o_vram_addr,
  output logic [7:0]             o_vram_din,
  input  logic [7:0]             i_vram_dout,
  output logic                   o_vram_ce,
  output logic                   o_vram_w,
  output logic [ROW_W-1:0]       o_cursor_row,
  output logic [COL_W-1:0]       o_cursor_col
);
  typedef enum logic [2:0] {IDLE, DECODE, WRITE, SCROLL, CLEAR} state_t;
  typedef enum logic [1:0] {P_RD, P_CP, P_BL, P_INIT} phase_t;
  localparam int TW = COL_W + 1;
  localparam logic [COL_W-1:0] CMAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] RMAX = ROW_W'(ROWS - 1);
  state_t state_q, state_d;
  phase_t ph_q, ph_d;
  logic [ROW_W-1:0] row_q, row_d, r_q, r_d;
  logic [COL_W-1:0] col_q, col_d, c_q, c_d, tab_col;
  logic [7:0] char_q, char_d, din_q, din_d;
  logic ce_q, ce_d, w_q, w_d, copy_q, copy_d;
  logic [ROW_W+COL_W-1:0] addr_q, addr_d;
  logic [TW-1:0] tab_sum;
  assign tab_sum = ({1'b0, col_q} | TW'(TAB_W - 1)) + TW'(1);
  assign tab_col = (tab_sum > TW'(COLS - 1)) ? CMAX : tab_sum[COL_W-1:0];
  assign o_ready = (state_q == IDLE) && !i_rst;
  assign o_vram_ce = ce_q;
  assign o_vram_w = w_q;
  assign o_vram_addr = addr_q;
  // copy writes forward the word read in the previous cycle straight from the VRAM
  assign o_vram_din = copy_q ? i_vram_dout : din_q;
  assign o_cursor_row = row_q;
  assign o_cursor_col = col_q;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    char_d = char_q;
    r_d = r_q;
    c_d = c_q;
    ph_d = ph_q;
    case (state_q)
      IDLE: if (i_valid) begin
        char_d = i_char;
        state_d = DECODE;
      end
      DECODE: begin
        state_d = IDLE;
        case (char_q)
          8'h00: ;
          8'h08, 8'h7f: col_d = (col_q == '0) ? '0 : col_q - COL_W'(1);
          8'h09: col_d = tab_col;
          8'h0a: if (row_q == RMAX) begin
            state_d = SCROLL;
            r_d = ROW_W'(1);
            c_d = '0;
            ph_d = P_RD;
          end else row_d = row_q + ROW_W'(1);
          8'h0d: col_d = '0;
          8'h0c: begin
            row_d = '0;
            col_d = '0;
            state_d = CLEAR;
            r_d = '0;
            c_d = '0;
            ph_d = P_BL;
          end
          default: state_d = WRITE;
        endcase
      end
      WRITE: begin
        col_d = (col_q == CMAX) ? '0 : col_q + COL_W'(1);
        row_d = (col_q == CMAX && row_q != RMAX) ? row_q + ROW_W'(1) : row_q;
        state_d = (col_q == CMAX && row_q == RMAX) ? SCROLL : IDLE;
        r_d = ROW_W'(1);
        c_d = '0;
        ph_d = P_RD;
      end
      SCROLL: begin
        if (ph_q == P_RD) ph_d = P_CP;
        else if (c_q != CMAX) begin
          c_d = c_q + COL_W'(1);
          ph_d = (ph_q == P_CP) ? P_RD : P_BL;
        end else if (ph_q == P_CP && r_q != RMAX) begin
          r_d = r_q + ROW_W'(1);
          c_d = '0;
          ph_d = P_RD;
        end else if (ph_q == P_CP) begin
          c_d = '0;
          ph_d = P_BL;
        end else state_d = IDLE;
      end
      CLEAR: begin
        if (ph_q == P_INIT) begin
          r_d = '0;
          c_d = '0;
          ph_d = P_BL;
        end else if (c_q != CMAX) c_d = c_q + COL_W'(1);
        else if (r_q != RMAX) begin
          r_d = r_q + ROW_W'(1);
          c_d = '0;
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ce_d = state_d == WRITE || state_d == SCROLL || state_d == CLEAR;
    w_d = ce_d && !(state_d == SCROLL && ph_d == P_RD);
    copy_d = state_d == SCROLL && ph_d == P_CP;
    addr_d = !ce_d ? '0 : (state_d == WRITE) ? {row_q, col_q} : {copy_d ? r_d - ROW_W'(1) : r_d, c_d};
    din_d = (state_d == WRITE) ? char_q : ce_d ? BLANK : 8'h00;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
      ph_q <= P_INIT;
      row_q <= '0;
      col_q <= '0;
      r_q <= '0;
      c_q <= '0;
      char_q <= '0;
      ce_q <= 1'b0;
      w_q <= 1'b0;
      copy_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      row_q <= row_d;
      col_q <= col_d;
      r_q <= r_d;
      c_q <= c_d;
      char_q <= char_d;
      ce_q <= ce_d;
      w_q <= w_d;
      copy_q <= copy_d;
      addr_q <= addr_d;
      din_q <= din_d;
    end
  end
endmodule

// File: tb/tb_term_ctrl.sv
// tb_term_ctrl: table vectors, corner sequences and random bytes against a screen-level reference model
module tb_term_ctrl;
  localparam int COLS = 60, ROWS = 17, COL_W = 6, ROW_W = 5, TAB_W = 8, AW = ROW_W + COL_W;
  localparam logic [7:0] BLANK = 8'h20;
  localparam int SCROLL_CYC = 2 * COLS * (ROWS - 1) + COLS;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0;
  logic [7:0] ch = 8'h00;
  logic ready, ce, w;
  logic [AW-1:0] addr;
  logic [7:0] din, dout = 8'h00;
  logic [ROW_W-1:0] crow;
  logic [COL_W-1:0] ccol;
  always #5 clk = ~clk;
  term_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_char(ch), .i_valid(valid), .o_ready(ready),
    .o_vram_addr(addr), .o_vram_din(din), .i_vram_dout(dout), .o_vram_ce(ce),
    .o_vram_w(w), .o_cursor_row(crow), .o_cursor_col(ccol)
  );
  logic [7:0] vram [0:(1<<AW)-1];
  int nwr = 0, nrd = 0, nbad = 0;
  int wlog[$];
  logic [7:0] dlog[$];
  always @(posedge clk) if (ce) begin
    if (int'(addr[COL_W-1:0]) >= COLS || int'(addr[AW-1:COL_W]) >= ROWS) nbad++;
    if (w) begin
      vram[addr] <= din;
      nwr++;
      wlog.push_back(int'(addr));
      dlog.push_back(din);
    end else begin
      dout <= vram[addr];
      nrd++;
    end
  end
  int checks = 0, errors = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  // screen-level reference model
  logic [7:0] em [ROWS][COLS];
  int m_row = 0, m_col = 0;
  task automatic m_clear();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) em[r][c] = BLANK;
  endtask
  task automatic m_scroll();
    for (int r = 0; r < ROWS - 1; r++) em[r] = em[r+1];
    for (int c = 0; c < COLS; c++) em[ROWS-1][c] = BLANK;
  endtask
  task automatic model(input logic [7:0] b, output int low, output int wr, output int rd);
    bit scr = 0;
    low = 1; wr = 0; rd = 0;
    case (b)
      8'h00: ;
      8'h08, 8'h7f: m_col = (m_col > 0) ? m_col - 1 : 0;
      8'h09: m_col = ((m_col / TAB_W + 1) * TAB_W > COLS - 1) ? COLS - 1 : (m_col / TAB_W + 1) * TAB_W;
      8'h0a: if (m_row == ROWS - 1) scr = 1; else m_row++;
      8'h0d: m_col = 0;
      8'h0c: begin m_row = 0; m_col = 0; m_clear(); low += ROWS * COLS; wr = ROWS * COLS; end
      default: begin
        em[m_row][m_col] = b; low = 2; wr = 1;
        if (m_col < COLS - 1) m_col++;
        else begin m_col = 0; if (m_row < ROWS - 1) m_row++; else scr = 1; end
      end
    endcase
    if (scr) begin
      m_scroll();
      low += SCROLL_CYC; wr += ROWS * COLS; rd += (ROWS - 1) * COLS;
    end
  endtask
  task automatic mem_chk(input string name);
    int bad = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++)
      if (vram[(r << COL_W) + c] !== em[r][c]) bad++;
    chk(name, bad, 0);
  endtask
  task automatic wait_ready(input string name, input int lim);
    int n = 0;
    while (!ready && n < lim) begin @(negedge clk); n++; end
    if (!ready) chk({name, "_timeout"}, 0, 1);
  endtask
  task automatic send(input logic [7:0] b, output int low);
    wait_ready("send", 4000);
    valid = 1'b1; ch = b;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    low = 0;
    while (!ready && low < 4000) begin low++; @(negedge clk); end
  endtask
  task automatic step(input logic [7:0] b, input string tag);
    int el, ew, er, low, w0, r0;
    w0 = nwr; r0 = nrd;
    model(b, el, ew, er);
    send(b, low);
    chk({tag, "_low"}, low, el);
    chk({tag, "_writes"}, nwr - w0, ew);
    chk({tag, "_reads"}, nrd - r0, er);
    chk({tag, "_row"}, int'(crow), m_row);
    chk({tag, "_col"}, int'(ccol), m_col);
    mem_chk({tag, "_mem"});
  endtask
  typedef struct {
    logic [7:0] ch;
    int row, col, low, wr, waddr;
    logic [7:0] wdin;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic [7:0] c, input int row, input int col, input int waddr = -1, input logic [7:0] wdin = 8'h00);
    bit prt = !(c inside {8'h00, 8'h08, 8'h09, 8'h0a, 8'h0c, 8'h0d, 8'h7f});
    tbl.push_back('{c, row, col, prt ? 2 : 1, prt ? 1 : 0, waddr, wdin});
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
  initial begin
    int low, w0, el, ew, er;
    logic [7:0] b;
    for (int i = 0; i < (1 << AW); i++) vram[i] <= 8'h80 | 8'($urandom_range(0, 127));
    ch = 8'h51; valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_ce", ce, 0);
    chk("rst_w", w, 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_din", int'(din), 0);
    chk("rst_row", int'(crow), 0);
    chk("rst_col", int'(ccol), 0);
    rst = 1'b0; valid = 1'b0;
    wait_ready("rst_clear", 3000);
    chk("rst_clear_writes", nwr, ROWS * COLS);
    chk("rst_clear_reads", nrd, 0);
    chk("rst_clear_badaddr", nbad, 0);
    chk("rst_clear_row", int'(crow), 0);
    chk("rst_clear_col", int'(ccol), 0);
    m_clear();
    mem_chk("rst_clear_mem");
    add(8'h0a, 1, 0); add(8'h0a, 2, 0); add(8'h0a, 3, 0);
    add("a", 3, 1); add("b", 3, 2); add("c", 3, 3); add("d", 3, 4); add("e", 3, 5);
    add("A", 3, 6, 'hC5, 8'h41);
    add(8'h0d, 3, 0); add("x", 3, 1); add("y", 3, 2); add("z", 3, 3);
    add(8'h09, 3, 8); add(8'h09, 3, 16); add(8'h09, 3, 24); add(8'h09, 3, 32);
    add(8'h09, 3, 40); add(8'h09, 3, 48); add(8'h09, 3, 56);
    add("p", 3, 57); add("q", 3, 58, 'hF9, 8'h71);
    add(8'h09, 3, 59); add(8'h09, 3, 59);
    add(8'h0d, 3, 0); add(8'h08, 3, 0); add(8'h7f, 3, 0);
    for (int i = 1; i <= 5; i++) add(8'h09, 3, 8 * i);
    add(8'h0d, 3, 0); add(8'h09, 3, 8); add(8'h08, 3, 7); add(8'h7f, 3, 6); add(8'h00, 3, 6);
    for (int i = 0; i < tbl.size(); i++) begin
      w0 = nwr; wlog.delete(); dlog.delete();
      model(tbl[i].ch, el, ew, er);
      send(tbl[i].ch, low);
      chk($sformatf("tbl%0d_low", i), low, tbl[i].low);
      chk($sformatf("tbl%0d_writes", i), nwr - w0, tbl[i].wr);
      chk($sformatf("tbl%0d_row", i), int'(crow), tbl[i].row);
      chk($sformatf("tbl%0d_col", i), int'(ccol), tbl[i].col);
      if (tbl[i].waddr >= 0) begin
        chk($sformatf("tbl%0d_waddr", i), wlog.size() > 0 ? wlog[0] : -1, tbl[i].waddr);
        chk($sformatf("tbl%0d_wdin", i), dlog.size() > 0 ? int'(dlog[0]) : -1, int'(tbl[i].wdin));
      end
    end
    mem_chk("tbl_mem");
    step(8'h0c, "ff_930");
    for (int i = 0; i < ROWS - 1; i++) step(8'h0a, "lf_down");
    for (int i = 0; i < 7; i++) step(8'h09, "tab_right");
    step("x", "pos_x"); step("y", "pos_y"); step("z", "pos_z");
    chk("corner_row", int'(crow), 16);
    chk("corner_col", int'(ccol), 59);
    @(negedge clk);
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
      em[r][c] = 8'(r * 16 + c % 16 + 1);
      vram[(r << COL_W) + c] <= 8'(r * 16 + c % 16 + 1);
    end
    @(negedge clk);
    wlog.delete();
    step("Z", "scroll_z");
    chk("scroll_z_first_waddr", wlog.size() > 0 ? wlog[0] : -1, (16 << COL_W) + 59);
    chk("scroll_z_moved", int'(vram[(15 << COL_W) + 59]), 8'h5A);
    chk("scroll_z_row", int'(crow), 16);
    chk("scroll_z_col", int'(ccol), 0);
    step(8'h09, "tab16");
    step(8'h0a, "lf_scroll");
    chk("lf_scroll_col", int'(ccol), 8);
    chk("scroll_badaddr", nbad, 0);
    step(8'h0c, "ff_home");
    for (int i = 0; i < 4; i++) step(8'h0a, "lf_to4");
    step(8'h0a, "lf_row4");
    chk("lf_row4_row", int'(crow), 5);
    for (int i = 0; i < ROWS - 1 - 5; i++) step(8'h0a, "lf_to16");
    wait_ready("mid", 4000);
    valid = 1'b1; ch = 8'h0a;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_scroll_ce", ce, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ce", ce, 0);
    rst = 1'b0;
    w0 = nwr;
    wait_ready("mid_clear", 3000);
    chk("mid_clear_writes", nwr - w0, ROWS * COLS);
    chk("mid_clear_row", int'(crow), 0);
    chk("mid_clear_col", int'(ccol), 0);
    m_clear(); m_row = 0; m_col = 0;
    mem_chk("mid_clear_mem");
    for (int i = 0; i < 250; i++) begin
      int r = $urandom_range(0, 99);
      b = r < 12 ? 8'h0a : r < 17 ? 8'h0d : r < 24 ? 8'h09 : r < 29 ? 8'h08 : r < 31 ? 8'h7f :
          r < 33 ? 8'h00 : r < 34 ? 8'h0c : r < 36 ? 8'($urandom_range(128, 255)) : r < 38 ? 8'h1b :
          8'($urandom_range(33, 126));
      step(b, $sformatf("rnd%0d", i));
    end
    chk("final_badaddr", nbad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
